// File: rtl/pad_mon_pkg.sv
// rtl/pad_mon_pkg.sv - shared state encoding and width constants for the pad supply monitor
package pad_mon_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RAMP  = 2'd1,
    ST_GOOD  = 2'd2,
    ST_FAULT = 2'd3
  } pad_state_e;

  localparam int FAULT_COUNT_W = 8;
  localparam int DEB_CNT_W     = 8;

  localparam logic [FAULT_COUNT_W-1:0] FAULT_COUNT_MAX = '1;

  // Fault history must stay meaningful after long runs, so it sticks at max rather than wrapping.
  function automatic logic [FAULT_COUNT_W-1:0] sat_inc(input logic [FAULT_COUNT_W-1:0] v);
    return (v == FAULT_COUNT_MAX) ? v : v + FAULT_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/pad_supply_monitor_if.sv
// rtl/pad_supply_monitor_if.sv - sense inputs and status outputs of the pad supply monitor
interface pad_supply_monitor_if;
  import pad_mon_pkg::*;

  logic                     VDDIO_SENSE;
  logic                     VSSIO_SENSE;
  logic                     FAULT_CLR;
  logic                     PWR_GOOD;
  logic                     IO_ENABLE;
  logic                     FAULT_IRQ;
  logic [FAULT_COUNT_W-1:0] FAULT_COUNT;
  logic [1:0]               STATE;

  modport master (
    output VDDIO_SENSE,
    output VSSIO_SENSE,
    output FAULT_CLR,
    input  PWR_GOOD,
    input  IO_ENABLE,
    input  FAULT_IRQ,
    input  FAULT_COUNT,
    input  STATE
  );

  modport slave (
    input  VDDIO_SENSE,
    input  VSSIO_SENSE,
    input  FAULT_CLR,
    output PWR_GOOD,
    output IO_ENABLE,
    output FAULT_IRQ,
    output FAULT_COUNT,
    output STATE
  );

endinterface

// File: rtl/pad_sync.sv
// rtl/pad_sync.sv - multi-flop synchronizer for one asynchronous pad sense level
module pad_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/pad_supply_monitor.sv
// rtl/pad_supply_monitor.sv - debounced pad-ring supply monitor with sticky fault reporting
module pad_supply_monitor
  import pad_mon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  pad_supply_monitor_if.slave  mon
);

  localparam logic [DEB_CNT_W-1:0] DEB_TARGET = DEB_CNT_W'(DEBOUNCE_CYCLES);

  logic w_vdd_sync;
  logic w_vss_sync;
  logic w_good;

  pad_state_e               r_state;
  pad_state_e               w_state_next;
  logic [DEB_CNT_W-1:0]     r_cnt;
  logic [DEB_CNT_W-1:0]     w_cnt_next;
  logic                     r_irq;
  logic                     w_irq_next;
  logic [FAULT_COUNT_W-1:0] r_fault_count;
  logic [FAULT_COUNT_W-1:0] w_fault_count_next;
  logic                     r_pwr_good;
  logic                     r_io_enable;

  pad_sync #(.STAGES(SYNC_STAGES)) u_sync_vdd (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_async (mon.VDDIO_SENSE),
    .o_sync  (w_vdd_sync)
  );

  pad_sync #(.STAGES(SYNC_STAGES)) u_sync_vss (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_async (mon.VSSIO_SENSE),
    .o_sync  (w_vss_sync)
  );

  assign w_good = w_vdd_sync & ~w_vss_sync;

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_irq_next         = r_irq;
    w_fault_count_next = r_fault_count;
    case (r_state)
      ST_OFF: begin
        if (w_good) begin
          w_state_next = ST_RAMP;
          w_cnt_next   = DEB_CNT_W'(1);
        end else begin
          w_cnt_next   = '0;
        end
      end
      ST_RAMP: begin
        // A dip while ramping is just an unstable supply, not a fault.
        if (!w_good) begin
          w_state_next = ST_OFF;
          w_cnt_next   = '0;
        end else if (r_cnt >= DEB_TARGET) begin
          w_state_next = ST_GOOD;
        end else begin
          w_cnt_next   = r_cnt + DEB_CNT_W'(1);
        end
      end
      ST_GOOD: begin
        // FAULT_CLR is not consulted here, so a coincident clear cannot mask the fault.
        if (!w_good) begin
          w_state_next       = ST_FAULT;
          w_irq_next         = 1'b1;
          w_fault_count_next = sat_inc(r_fault_count);
        end
      end
      ST_FAULT: begin
        w_cnt_next = '0;
        if (mon.FAULT_CLR) begin
          w_state_next = ST_OFF;
          w_irq_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_OFF;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_OFF;
      r_cnt         <= '0;
      r_irq         <= 1'b0;
      r_fault_count <= '0;
      r_pwr_good    <= 1'b0;
      r_io_enable   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_irq         <= w_irq_next;
      r_fault_count <= w_fault_count_next;
      r_pwr_good    <= (w_state_next == ST_GOOD);
      r_io_enable   <= r_pwr_good;
    end
  end

  assign mon.PWR_GOOD    = r_pwr_good;
  assign mon.IO_ENABLE   = r_io_enable;
  assign mon.FAULT_IRQ   = r_irq;
  assign mon.FAULT_COUNT = r_fault_count;
  assign mon.STATE       = r_state;

endmodule
